// File: rtl/dna_pkg.sv
// Shared definitions for the DNA streaming stages: nucleotide codes, the
// streamer state encoding and the bases-per-word derivation.
package dna_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Two bits per nucleotide, packed big-endian inside a memory word.
  function automatic int bases_per_word(input int data_width);
    return data_width / 2;
  endfunction

endpackage

// File: rtl/base_word_unpacker.sv
// Current-word shift register: presents the oldest base in the top two bits and
// counts how many valid bases of the loaded word remain.
module base_word_unpacker
  import dna_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(bases_per_word(DATA_WIDTH) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic [CNT_W-1:0]      load_count,
  input  logic                  shift,
  output logic [1:0]            base,
  output logic                  word_empty,
  output logic                  word_last
);

  logic [DATA_WIDTH-1:0] word_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  empty_reg;

  // A load wins over a shift so a refill can land on the edge the old word drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_reg  <= '0;
      count_reg <= '0;
      empty_reg <= 1'b1;
    end else if (load) begin
      word_reg  <= load_word;
      count_reg <= load_count;
      empty_reg <= (load_count == '0);
    end else if (shift && !empty_reg) begin
      word_reg  <= word_reg << 2;
      count_reg <= count_reg - CNT_W'(1);
      empty_reg <= (count_reg == CNT_W'(1));
    end
  end

  assign base       = word_reg[DATA_WIDTH-1 -: 2];
  assign word_empty = empty_reg;
  assign word_last  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/ref_base_streamer.sv
// Reads a run of packed reference words and streams them one nucleotide per
// cycle; a one-word prefetch buffer covers the memory's registered read.
module ref_base_streamer
  import dna_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_bases,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  base_valid,
  input  logic                  base_ready,
  output logic [1:0]            base_data,
  output logic                  base_last
);

  localparam int BPW   = bases_per_word(DATA_WIDTH);
  localparam int CNT_W = $clog2(BPW + 1);
  localparam logic [LEN_WIDTH-1:0]  BPW_LEN   = LEN_WIDTH'(BPW);
  localparam logic [LEN_WIDTH:0]    BPW_WRD   = (LEN_WIDTH + 1)'(BPW);
  localparam logic [LEN_WIDTH:0]    BPW_M1    = (LEN_WIDTH + 1)'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_t                state_reg;
  logic                  busy_reg, done_reg, last_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic                  rd_s1_reg, rd_s2_reg;
  logic [DATA_WIDTH-1:0] pref_reg;
  logic                  pref_valid_reg;
  logic [LEN_WIDTH:0]    words_left_reg;
  logic [LEN_WIDTH-1:0]  load_left_reg, job_left_reg;

  logic                  word_empty, word_last;
  logic [1:0]            unp_base;
  logic                  hs, cur_free, load_from_pref, load_from_mem, unp_load;
  logic                  pref_fill, pref_valid_next, issue;
  logic [CNT_W-1:0]      load_count;
  logic [DATA_WIDTH-1:0] load_word;
  logic [LEN_WIDTH:0]    num_words;
  logic [1:0]            occupancy;

  // Words held or in flight (current, prefetch, read pipeline) never exceed two,
  // so an arriving word always has somewhere to land.
  always_comb begin
    hs              = !word_empty && base_ready;
    cur_free        = word_empty || (hs && word_last);
    load_from_pref  = cur_free && pref_valid_reg;
    load_from_mem   = cur_free && !pref_valid_reg && rd_s2_reg;
    unp_load        = load_from_pref || load_from_mem;
    load_word       = load_from_pref ? pref_reg : mem_dout;
    load_count      = (load_left_reg >= BPW_LEN) ? CNT_W'(BPW) : CNT_W'(load_left_reg);
    pref_fill       = rd_s2_reg && !load_from_mem;
    pref_valid_next = pref_fill || (pref_valid_reg && !load_from_pref);
    occupancy       = {1'b0, (!cur_free || unp_load)} + {1'b0, pref_valid_next} + {1'b0, rd_s1_reg};
    issue           = busy_reg && (words_left_reg != '0) && (occupancy < 2'd2);
    num_words       = ({1'b0, num_bases} + BPW_M1) / BPW_WRD;
  end

  base_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_unpacker (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (unp_load),
    .load_word  (load_word),
    .load_count (load_count),
    .shift      (hs),
    .base       (unp_base),
    .word_empty (word_empty),
    .word_last  (word_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      last_reg       <= 1'b0;
      mem_addr_reg   <= '0;
      rd_s1_reg      <= 1'b0;
      rd_s2_reg      <= 1'b0;
      pref_reg       <= '0;
      pref_valid_reg <= 1'b0;
      words_left_reg <= '0;
      load_left_reg  <= '0;
      job_left_reg   <= '0;
    end else begin
      done_reg       <= 1'b0;
      rd_s1_reg      <= issue;
      rd_s2_reg      <= rd_s1_reg;
      pref_valid_reg <= pref_valid_next;
      if (pref_fill) pref_reg <= mem_dout;
      if (issue) begin
        mem_addr_reg   <= mem_addr_reg + ADDR_STEP;
        words_left_reg <= words_left_reg - (LEN_WIDTH + 1)'(1);
      end
      if (unp_load) load_left_reg <= load_left_reg - LEN_WIDTH'(load_count);
      if (hs) begin
        job_left_reg <= job_left_reg - LEN_WIDTH'(1);
        last_reg     <= (job_left_reg == LEN_WIDTH'(2));
      end

      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          if (start) begin
            if (num_bases == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg      <= FETCH;
              busy_reg       <= 1'b1;
              mem_addr_reg   <= base_addr;
              rd_s1_reg      <= 1'b1;
              words_left_reg <= num_words - (LEN_WIDTH + 1)'(1);
              load_left_reg  <= num_bases;
              job_left_reg   <= num_bases;
              last_reg       <= (num_bases == LEN_WIDTH'(1));
            end
          end
        end
        FETCH: if (load_from_mem) state_reg <= STREAM;
        STREAM: begin
          if (hs && last_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign mem_addr   = mem_addr_reg;
  assign base_valid = !word_empty;
  assign base_data  = unp_base;
  assign base_last  = last_reg;

endmodule

// File: tb/tb_ref_base_streamer.sv
// Scoreboard bench: jobs push their expected base stream into a queue and a
// negedge monitor pops and compares every handshake against it.
module tb_ref_base_streamer;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, base_valid, base_ready, base_last;
  logic [31:0] base_addr, mem_addr, mem_dout;
  logic [15:0] num_bases;
  logic [1:0]  base_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [logic [31:0]];
  logic [2:0]  exp_q [$];
  bit          seen_addr [logic [31:0]];
  logic [31:0] max_addr;
  bit          ready_rand = 1'b0;
  bit          job_done = 1'b0;
  bit          first_seen = 1'b1;
  bit          stall_prev = 1'b0;
  logic [1:0]  stall_data;
  int          ncyc = 0;
  int          start_neg = -100;
  int          done_due = -1;
  int          last_hs_neg = -1;

  ref_base_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_bases  (num_bases),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .base_valid (base_valid),
    .base_ready (base_ready),
    .base_data  (base_data),
    .base_last  (base_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Registered-read reference memory
  always @(posedge clk) mem_dout <= mem_rd(mem_addr);

  // Expected stream: base i lives in word i/16, slot i%16 counted from the MSBs.
  function automatic void push_job(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [1:0]  b;
    for (int i = 0; i < n; i++) begin
      w = mem_rd(a + 32'(4 * (i / 16)));
      b = 2'((w >> (30 - 2 * (i % 16))) & 32'h3);
      exp_q.push_back({b, (i == n - 1)});
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin
    base_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      base_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (start && !busy) begin
        start_neg   = ncyc;
        first_seen  = (num_bases == 16'd0);
        last_hs_neg = -1;
        seen_addr.delete();
        max_addr    = 32'h0;
        if (num_bases == 16'd0) done_due = ncyc + 1;
      end
      if (busy) begin
        seen_addr[mem_addr] = 1'b1;
        if (mem_addr > max_addr) max_addr = mem_addr;
      end
      if (stall_prev) begin
        tests++;
        if (!base_valid || base_data !== stall_data) begin
          fails++;
          $display("FAIL stall_hold: valid=%0b data=%0d required valid=1 data=%0d",
                   base_valid, base_data, stall_data);
        end
      end
      if (base_valid && !first_seen) begin
        first_seen = 1'b1;
        tests++;
        if (ncyc != start_neg + 3) begin
          fails++;
          $display("FAIL first_base_latency: %0d cycles, required 3", ncyc - start_neg);
        end
      end
      if (base_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_base: data=%0d last=%0b with nothing expected", base_data, base_last);
        end else if (base_ready) begin
          e = exp_q.pop_front();
          tests++;
          if ({base_data, base_last} !== e) begin
            fails++;
            $display("FAIL base: got data=%0d last=%0b required data=%0d last=%0b",
                     base_data, base_last, e[2:1], e[0]);
          end
          if (!ready_rand && last_hs_neg >= 0) begin
            tests++;
            if (ncyc != last_hs_neg + 1) begin
              fails++;
              $display("FAIL stream_gap: %0d cycles between bases, required 1", ncyc - last_hs_neg);
            end
          end
          last_hs_neg = ncyc;
          if (e[0]) done_due = ncyc + 1;
        end
      end
      if (done) begin
        tests++;
        if (ncyc != done_due || busy) begin
          fails++;
          $display("FAIL done_pulse: at cycle %0d busy=%0b, required cycle %0d busy=0",
                   ncyc, busy, done_due);
        end
        done_due = -1;
        job_done = 1'b1;
      end
      stall_prev = base_valid && !base_ready;
      stall_data = base_data;
    end
    ncyc++;
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && !job_done; i++) @(posedge clk);
    tests++;
    if (!job_done) begin
      fails++;
      $display("FAIL %s_timeout: done=0 after 3000 cycles, required done pulse", name);
    end
  endtask

  task automatic run_job(input string name, input logic [31:0] a, input int n,
                         input bit rr, input bit inject);
    int nw;
    ready_rand = rr;
    push_job(a, n);
    job_done = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = a;
    num_bases = 16'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = $urandom;
    num_bases = 16'($urandom);
    if (inject) begin
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 32'h200;
      num_bases = 16'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(name);
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    if (n > 0) begin
      nw = (n + 15) / 16;
      chk({name, "_reads"}, 32'(seen_addr.num()), 32'(nw));
      chk({name, "_max_addr"}, max_addr, a + 32'(4 * (nw - 1)));
    end
    $display("[TB] job %s addr=%0h bases=%0d ready_rand=%0b complete", name, a, n, rr);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"},       32'(busy),       32'd0);
    chk({name, "_done"},       32'(done),       32'd0);
    chk({name, "_mem_addr"},   mem_addr,        32'd0);
    chk({name, "_base_valid"}, 32'(base_valid), 32'd0);
    chk({name, "_base_data"},  32'(base_data),  32'd0);
    chk({name, "_base_last"},  32'(base_last),  32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 32'h0;
    num_bases = 16'd0;
    mem[32'h100] = 32'h1B1B1B1B;
    mem[32'h200] = 32'hFFFFFFFF;
    mem[32'h204] = 32'h00000000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_job("pattern16", 32'h100, 16, 1'b0, 1'b1);
    run_job("two_words_plus", 32'h200, 40, 1'b0, 1'b0);
    run_job("partial5", 32'h100, 5, 1'b0, 1'b0);
    run_job("len48_ready", 32'h300, 48, 1'b0, 1'b0);
    run_job("len48_stall", 32'h300, 48, 1'b1, 1'b0);
    run_job("zero_len", 32'h100, 0, 1'b0, 1'b0);

    // Abort a job mid-stream with reset
    ready_rand = 1'b0;
    push_job(32'h200, 40);
    job_done = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 32'h200;
    num_bases = 16'd40;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 30; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    done_due = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("mid_reset_no_done", 32'(job_done), 32'd0);
    $display("[TB] job mid_reset aborted");

    run_job("after_reset", 32'h100, 16, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_job("random", 32'h1000 + 32'($urandom_range(0, 255) * 4),
              $urandom_range(1, 70), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
